// File: rtl/pipeline_slot_ctrl.sv
// rtl/pipeline_slot_ctrl.sv - N-slot in-order pipeline register chain with stall, bubble collapse and flush
module pipeline_slot_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = 64,
  parameter int CNT_W      = 32,
  localparam int IDX_W     = $clog2(NUM_STAGES),
  localparam int OCC_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic [NUM_STAGES-1:0]        slot_valid_o,
  output logic [NUM_STAGES*DATA_W-1:0] slot_data_o,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_res_i,
  input  logic [NUM_STAGES-1:0]        stall_req_i,
  input  logic                         flush_valid,
  input  logic [IDX_W-1:0]             flush_stage,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic [OCC_W-1:0]             occupancy,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             retire_cnt
);

  logic [NUM_STAGES-1:0]        v;
  logic [NUM_STAGES*DATA_W-1:0] data_q;
  logic [NUM_STAGES-1:0]        hold;
  logic                         flush_eff;
  int                           flush_k;

  // A slot holds only if it is valid and it or something older cannot move.
  always_comb begin
    hold = '0;
    hold[NUM_STAGES-1] = v[NUM_STAGES-1] & stall_req_i[NUM_STAGES-1];
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
      hold[i] = v[i] & (stall_req_i[i] | hold[i+1]);
    end
  end

  assign flush_k   = int'(flush_stage);
  assign flush_eff = flush_valid & (flush_k < NUM_STAGES);

  assign in_ready     = ~hold[0] & ~flush_eff;
  assign out_valid    = v[NUM_STAGES-1] & ~stall_req_i[NUM_STAGES-1];
  assign out_data     = stage_res_i[(NUM_STAGES-1)*DATA_W +: DATA_W];
  assign slot_valid_o = v;
  assign slot_data_o  = data_q;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v          <= '0;
      data_q     <= '0;
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (!hold[0]) begin
        data_q[0 +: DATA_W] <= in_data;
      end
      if (flush_eff) begin
        v[0] <= 1'b0;
      end else if (!hold[0]) begin
        v[0] <= in_valid;
      end
      // Packets younger than the flushing stage die both in place and on their way to the next slot.
      for (int i = 0; i < NUM_STAGES - 1; i++) begin
        if (!hold[i+1]) begin
          data_q[(i+1)*DATA_W +: DATA_W] <= stage_res_i[i*DATA_W +: DATA_W];
        end
        if (flush_eff && (i + 1 < flush_k)) begin
          v[i+1] <= 1'b0;
        end else if (!hold[i+1]) begin
          v[i+1] <= v[i] & ~stall_req_i[i] & ~(flush_eff && (i < flush_k));
        end
      end
      if (|hold) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (out_valid) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_slot_ctrl.sv
// tb/tb_pipeline_slot_ctrl.sv - self-checking bench for pipeline_slot_ctrl
module tb_pipeline_slot_ctrl;

  localparam int N   = 5;
  localparam int W   = 16;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [N-1:0]   slot_valid_o;
  logic [N*W-1:0] slot_data_o;
  logic [N*W-1:0] stage_res_i;
  logic [N-1:0]   stall_req_i;
  logic           flush_valid;
  logic [2:0]     flush_stage;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     occupancy;
  logic [CW-1:0]  stall_cnt;
  logic [CW-1:0]  retire_cnt;

  pipeline_slot_ctrl #(.NUM_STAGES(N), .DATA_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .slot_valid_o(slot_valid_o), .slot_data_o(slot_data_o), .stage_res_i(stage_res_i),
    .stall_req_i(stall_req_i), .flush_valid(flush_valid), .flush_stage(flush_stage),
    .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // External stage logic: each stage adds one, so a packet d retires as d+N.
  always_comb begin
    stage_res_i = '0;
    for (int i = 0; i < N; i++) begin
      stage_res_i[i*W +: W] = slot_data_o[i*W +: W] + W'(1);
    end
  end

  typedef struct packed {
    logic [N-1:0] stall;
    logic         flush;
    logic [2:0]   fstage;
    logic         exp_ready;
    logic         exp_out_valid;
    logic [2:0]   exp_occ;
    logic [CW-1:0] exp_stall_cnt;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] nd;
  logic [W-1:0] exp_d;
  bit           acc;
  vec_t         vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic half_a();
    @(negedge clk);
  endtask

  task automatic half_b();
    acc = in_valid && in_ready && !rst;
    if (acc) sb_q.push_back(in_data + W'(N));
    if (!rst && out_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_retire actual=%0h expected=none", out_data);
      end else begin
        exp_d = sb_q.pop_front();
        if (out_data !== exp_d) begin
          failures++;
          $display("FAIL sb_out_data actual=%0h expected=%0h", out_data, exp_d);
        end
      end
    end
    if (acc) nd = nd + W'(1);
    @(posedge clk);
    #1;
    in_data = nd;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    stall_req_i = '0;
    flush_valid = 1'b0;
    flush_stage = '0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
    nd = W'(1);
    in_data = nd;
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    stall_req_i = '0;
    flush_valid = 1'b0;
    repeat (8) tick();
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic fill();
    do_reset();
    in_valid = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{5'b01000, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 4'd0};
    vecs[1] = '{5'b01000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4, 4'd1};
    vecs[2] = '{5'b00000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd4, 4'd2};
    vecs[3] = '{5'b00000, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 4'd2};
    vecs[4] = '{5'b00000, 1'b1, 3'd7, 1'b1, 1'b1, 3'd5, 4'd2};
    vecs[5] = '{5'b10000, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, 4'd2};
    vecs[6] = '{5'b00000, 1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 4'd3};

    nd = W'(1);
    in_data = nd;
    do_reset();
    half_a();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_slot_valid", slot_valid_o, 0);
    chk("rst_slot_data", slot_data_o, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
    half_b();

    // Unstalled stream: first retire N cycles after first accept
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      half_a();
      chk("t1_out_valid", out_valid, (c >= N) ? 1 : 0);
      chk("t1_occ", occupancy, (c < N) ? c : N);
      half_b();
    end
    drain("t1_drain");

    // Table: stall at stage 3, out-of-range flush, retire stall
    fill();
    for (int r = 0; r < 7; r++) begin
      stall_req_i = vecs[r].stall;
      flush_valid = vecs[r].flush;
      flush_stage = vecs[r].fstage;
      half_a();
      chk($sformatf("t2_ready_r%0d", r), in_ready, vecs[r].exp_ready);
      chk($sformatf("t2_out_valid_r%0d", r), out_valid, vecs[r].exp_out_valid);
      chk($sformatf("t2_occ_r%0d", r), occupancy, vecs[r].exp_occ);
      chk($sformatf("t2_stall_cnt_r%0d", r), stall_cnt, vecs[r].exp_stall_cnt);
      half_b();
    end
    drain("t2_drain");

    // Stall on an empty slot must not hold anything
    do_reset();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    tick();
    stall_req_i = 5'b00010;
    half_a();
    chk("t3_in_ready", in_ready, 1);
    chk("t3_occ", occupancy, 2);
    chk("t3_slot_valid", slot_valid_o, 5'b01001);
    half_b();
    stall_req_i = '0;
    in_valid = 1'b0;
    half_a();
    chk("t3_slot_valid_next", slot_valid_o, 5'b10011);
    chk("t3_slot1_data", slot_data_o[1*W +: W], 3);
    chk("t3_stall_cnt", stall_cnt, 0);
    half_b();
    drain("t3_drain");

    // Flush at stage 2 on a full pipe
    fill();
    flush_valid = 1'b1;
    flush_stage = 3'd2;
    half_a();
    chk("t4_in_ready", in_ready, 0);
    half_b();
    flush_valid = 1'b0;
    in_valid = 1'b0;
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    half_a();
    chk("t4_slot_valid", slot_valid_o, 5'b11000);
    chk("t4_occ", occupancy, 2);
    chk("t4_slot3_data", slot_data_o[3*W +: W], 6);
    half_b();
    drain("t4_drain");

    // Flush combined with stalls on both sides of the flush point
    fill();
    flush_valid = 1'b1;
    flush_stage = 3'd2;
    stall_req_i = 5'b01010;
    half_a();
    chk("t5_in_ready", in_ready, 0);
    chk("t5_out_valid", out_valid, 1);
    half_b();
    flush_valid = 1'b0;
    stall_req_i = '0;
    in_valid = 1'b0;
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    half_a();
    chk("t5_slot_valid", slot_valid_o, 5'b01100);
    chk("t5_slot2_data", slot_data_o[2*W +: W], 5);
    chk("t5_slot3_data", slot_data_o[3*W +: W], 5);
    chk("t5_stall_cnt", stall_cnt, 1);
    half_b();
    drain("t5_drain");

    // Flush at stage 0 only clears slot 0 and the input
    fill();
    flush_valid = 1'b1;
    flush_stage = 3'd0;
    half_a();
    chk("k0_in_ready", in_ready, 0);
    half_b();
    flush_valid = 1'b0;
    in_valid = 1'b0;
    half_a();
    chk("k0_slot_valid", slot_valid_o, 5'b11110);
    half_b();
    drain("k0_drain");

    // Retire counter wrap, then reset mid-stream
    do_reset();
    in_valid = 1'b1;
    for (int c = 0; c < 22; c++) begin
      half_a();
      if (c == 20) chk("t6_retire_15", retire_cnt, 15);
      if (c == 21) chk("t6_retire_wrap", retire_cnt, 0);
      half_b();
    end
    rst = 1'b1;
    stall_req_i = 5'b00100;
    flush_valid = 1'b1;
    flush_stage = 3'd1;
    tick();
    rst = 1'b0;
    stall_req_i = '0;
    flush_valid = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    half_a();
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_slot_valid", slot_valid_o, 0);
    chk("t6_rst_retire", retire_cnt, 0);
    chk("t6_rst_stall", stall_cnt, 0);
    half_b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
